synth_frame_mixer_seq: RTL and testbench
========================================

// Module: synth_frame_mixer_seq
// PURPOSE
//  Time-multiplexed frame sequencer plus multi-channel output accumulator for the synth engine.
//  On each sample trigger it sweeps the voice x envelope slot index across VOICES*V_ENVS cycles.
//  Signed per-slot samples returned by the osc/mixer pipeline are accumulated into NUM_CH routed output buses.
//  Each bus is scaled, saturated and published once per frame.
//  Generalises the fixed stereo clock-gen/mixer pair to N channels, parametrised latency, clip and overrun reporting.
// PARAMETERS
//  VOICES   32                       voices
//  V_ENVS   16                       envelope slots per voice
//  V_WIDTH  utils::clogb2(VOICES)    voice index width
//  E_WIDTH  utils::clogb2(V_ENVS)    slot-in-voice index width
//  NUM_CH   4                        output channels
//  C_WIDTH  utils::clogb2(NUM_CH)    channel select width (min 1)
//  IN_W     17                       signed sample_in width
//  OUT_W    24                       signed output width per channel
//  LAT      2                        cycles from slot issue to matching sample_in (>=1)
//  SHIFT    4                        arithmetic right shift before saturation
// PORTS
//  AUDIO_CLK    in   1                        clock
//  reset_reg_N  in   1                        sync active-low reset
//  trig         in   1                        frame start request, single-cycle pulse
//  busy         out  1                        high in SWEEP/DRAIN/PUBLISH
//  xxxx         out  V_WIDTH+E_WIDTH          current slot index {voice,env}
//  slot_valid   out  1                        xxxx valid this cycle
//  xxxx_zero    out  1                        slot_valid && xxxx==0
//  sample_in    in   IN_W                     signed sample for slot issued LAT cycles earlier
//  ch_sel       in   C_WIDTH                  destination channel of sample_in
//  ch_out       out  NUM_CH*OUT_W             published channels, ch0 in LSBs
//  out_valid    out  1                        one-cycle publish strobe
//  clip         out  NUM_CH                   per-channel saturation flag of last publish
//  overrun      out  1                        sticky: trig seen while busy
// BEHAVIOUR
//  Reset (reset_reg_N=0 at clock edge, any state)
//   - Enters IDLE.
//   - All outputs 0; accumulators 0; LAT valid pipeline flushed; in-flight frame discarded.
//  Slot count: SLOTS = VOICES*V_ENVS. ACC_W = IN_W+V_WIDTH+E_WIDTH, so accumulation never overflows.
//  FSM
//   - IDLE:    trig=1 -> SWEEP; clear all accumulators; xxxx=0.
//   - SWEEP:   slot_valid=1 every cycle; xxxx increments by 1; after xxxx=SLOTS-1 -> DRAIN; xxxx returns to 0.
//   - DRAIN:   exactly LAT cycles, slot_valid=0, then -> PUBLISH.
//   - PUBLISH: one cycle; then -> IDLE.
//  Timing (trig sampled at end of cycle T)
//   - Slot cycles are T+1..T+SLOTS.
//   - sample_in/ch_sel are sampled when the internal LAT-deep copy of slot_valid is 1, i.e. cycles T+1+LAT..T+SLOTS+LAT.
//   - Sample is sign-extended to ACC_W and added to acc[ch_sel].
//   - ch_sel>=NUM_CH: sample dropped.
//  Publish
//   - At end of PUBLISH, each channel registers ch = sat(acc>>>SHIFT, OUT_W).
//   - Saturation clamps to +2^(OUT_W-1)-1 / -2^(OUT_W-1); clip[c] is set when clamped.
//   - out_valid=1 for cycle T+SLOTS+LAT+2 only.
//   - ch_out and clip hold until the next publish or reset.
//  trig outside IDLE: ignored, overrun set to 1 (cleared only by reset); frame in progress unaffected.
//  Max frame rate: one trig per SLOTS+LAT+2 cycles; trig in the out_valid cycle (IDLE) is accepted.
//  Reset mid-SWEEP/DRAIN: no publish; ch_out and clip return to 0.
// TESTING (bench config VOICES=2, V_ENVS=2, NUM_CH=2, IN_W=8, OUT_W=8, LAT=2, SHIFT=0 unless noted)
//  1. Reset
//     -> busy=0, slot_valid=0, ch_out=0, clip=0, overrun=0, out_valid=0.
//  2. trig at T, sample_in=+10 to ch0 for all 4 slots
//     -> xxxx 0,1,2,3 at T+1..T+4; xxxx_zero only at T+1;
//     -> out_valid only at T+8; ch0=40, ch1=0, clip=0.
//  3. Slots 0..3 send +100,+100 to ch0 and -100,-100 to ch1
//     -> ch0=127, ch1=-128, clip=2'b11.
//  4. Second trig at T+3
//     -> overrun=1; frame completes normally, out_valid at T+8;
//     -> new trig at T+8 accepted, next out_valid at T+16.
//  5. reset_reg_N low at T+3 for one cycle
//     -> IDLE, no out_valid; ch_out=0;
//     -> next trig yields correct fresh sums (accumulators cleared).
//  6. ch_sel=3 with NUM_CH=3; defaults with SHIFT=4 and all 512 slots=+1000 to ch0
//     -> sample dropped; ch0=32000, clip[0]=0.

Source files
------------

// File: rtl/synth_frame_mixer_seq.sv
// Frame sequencer that sweeps the {voice,env} slot index once per trigger and
// accumulates the returned signed samples into NUM_CH saturated output buses.
module synth_frame_mixer_seq #(
  parameter int VOICES  = 32,
  parameter int V_ENVS  = 16,
  parameter int V_WIDTH = (VOICES > 1) ? $clog2(VOICES) : 1,
  parameter int E_WIDTH = (V_ENVS > 1) ? $clog2(V_ENVS) : 1,
  parameter int NUM_CH  = 4,
  parameter int C_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int IN_W    = 17,
  parameter int OUT_W   = 24,
  parameter int LAT     = 2,
  parameter int SHIFT   = 4
) (
  input  logic                         AUDIO_CLK,
  input  logic                         reset_reg_N,
  input  logic                         trig,
  output logic                         busy,
  output logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
  output logic                         slot_valid,
  output logic                         xxxx_zero,
  input  logic [IN_W-1:0]              sample_in,
  input  logic [C_WIDTH-1:0]           ch_sel,
  output logic [NUM_CH*OUT_W-1:0]      ch_out,
  output logic                         out_valid,
  output logic [NUM_CH-1:0]            clip,
  output logic                         overrun
);

  localparam int SW    = V_WIDTH + E_WIDTH;
  localparam int SLOTS = VOICES * V_ENVS;
  localparam int ACC_W = IN_W + V_WIDTH + E_WIDTH;
  localparam int EW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int DW    = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [SW-1:0]        LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [DW-1:0]        LAST_DRN  = DW'(LAT - 1);
  localparam logic signed [EW-1:0] SAT_MAX   = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWEEP   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  state_t                     state_q;
  logic [SW-1:0]              xxxx_q;
  logic                       slot_valid_q;
  logic                       xxxx_zero_q;
  logic                       busy_q;
  logic [DW-1:0]              drain_q;
  logic                       out_valid_q;
  logic                       overrun_q;
  logic [NUM_CH*OUT_W-1:0]    ch_out_q;
  logic [NUM_CH-1:0]          clip_q;
  logic [LAT-1:0]             vpipe_q;
  logic signed [ACC_W-1:0]    acc_q [NUM_CH];

  logic                       frame_start_s;
  logic signed [ACC_W-1:0]    sample_ext_s;
  logic [OUT_W:0]             sat_s [NUM_CH];

  // Returns {clipped, value} for an accumulator after the output scaling shift.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    logic signed [EW-1:0]    wide;
    shifted = acc >>> SHIFT;
    wide    = {{(EW - ACC_W){shifted[ACC_W-1]}}, shifted};
    if (wide > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (wide < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, wide[OUT_W-1:0]};
    end
  endfunction

  assign frame_start_s = (state_q == ST_IDLE) && trig;
  assign sample_ext_s  = {{(ACC_W - IN_W){sample_in[IN_W-1]}}, sample_in};

  // Saturated view of every accumulator, consumed in the publish cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sat_s[c] = sat_fn(acc_q[c]);
    end
  end

  // Frame sequencer with all externally visible status registered.
  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_reg_N) begin
      state_q      <= ST_IDLE;
      xxxx_q       <= '0;
      slot_valid_q <= 1'b0;
      xxxx_zero_q  <= 1'b0;
      busy_q       <= 1'b0;
      drain_q      <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      ch_out_q     <= '0;
      clip_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (trig && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q      <= ST_SWEEP;
            xxxx_q       <= '0;
            slot_valid_q <= 1'b1;
            xxxx_zero_q  <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_SWEEP: begin
          xxxx_zero_q <= 1'b0;
          if (xxxx_q == LAST_SLOT) begin
            state_q      <= ST_DRAIN;
            xxxx_q       <= '0;
            slot_valid_q <= 1'b0;
            drain_q      <= '0;
          end else begin
            xxxx_q <= xxxx_q + SW'(1);
          end
        end
        // Wait for the last in-flight sample to come back from the pipeline.
        ST_DRAIN: begin
          if (drain_q == LAST_DRN) begin
            state_q <= ST_PUBLISH;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        ST_PUBLISH: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            ch_out_q[c*OUT_W +: OUT_W] <= sat_s[c][OUT_W-1:0];
            clip_q[c]                  <= sat_s[c][OUT_W];
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          slot_valid_q <= 1'b0;
          xxxx_zero_q  <= 1'b0;
        end
      endcase
    end
  end

  // Delayed slot_valid marks which sample_in beats belong to the current sweep.
  always_ff @(posedge AUDIO_CLK) begin
    if (!reset_reg_N) begin
      vpipe_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      vpipe_q <= LAT'({vpipe_q, slot_valid_q});
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_start_s) begin
          acc_q[c] <= '0;
        end else if (vpipe_q[LAT-1] && (ch_sel == C_WIDTH'(c))) begin
          acc_q[c] <= acc_q[c] + sample_ext_s;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign xxxx       = xxxx_q;
  assign slot_valid = slot_valid_q;
  assign xxxx_zero  = xxxx_zero_q;
  assign ch_out     = ch_out_q;
  assign out_valid  = out_valid_q;
  assign clip       = clip_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_synth_frame_mixer_seq.sv
// Randomized bench for synth_frame_mixer_seq: a small 4-slot instance and a
// default-sized 3-channel instance, both checked against a frame-level sum model.
module tb_synth_frame_mixer_seq;

  localparam int A_SLOTS = 4;
  localparam int A_LAT   = 2;
  localparam int A_FR    = A_SLOTS + A_LAT + 2;
  localparam int B_SLOTS = 512;
  localparam int B_LAT   = 2;
  localparam int B_FR    = B_SLOTS + B_LAT + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        trig_a, busy_a, sv_a, zero_a, ov_a, ovr_a, ch_a;
  logic [1:0]  xxxx_a, clip_a;
  logic [7:0]  smp_a;
  logic [15:0] chout_a;

  logic        trig_b, busy_b, sv_b, zero_b, ov_b, ovr_b;
  logic [8:0]  xxxx_b;
  logic [16:0] smp_b;
  logic [1:0]  ch_b;
  logic [71:0] chout_b;
  logic [2:0]  clip_b;

  int          vals_a [A_SLOTS];
  int          chs_a  [A_SLOTS];
  int          vals_b [B_SLOTS];
  int          chs_b  [B_SLOTS];
  logic [15:0] exp_ch_a;
  logic [1:0]  exp_clip_a;
  bit          exp_ovr_a;

  synth_frame_mixer_seq #(
    .VOICES(2), .V_ENVS(2), .NUM_CH(2), .IN_W(8), .OUT_W(8), .LAT(A_LAT), .SHIFT(0)
  ) dut_a (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n), .trig(trig_a), .busy(busy_a),
    .xxxx(xxxx_a), .slot_valid(sv_a), .xxxx_zero(zero_a), .sample_in(smp_a),
    .ch_sel(ch_a), .ch_out(chout_a), .out_valid(ov_a), .clip(clip_a), .overrun(ovr_a)
  );

  synth_frame_mixer_seq #(
    .NUM_CH(3)
  ) dut_b (
    .AUDIO_CLK(clk), .reset_reg_N(rst_n), .trig(trig_b), .busy(busy_b),
    .xxxx(xxxx_b), .slot_valid(sv_b), .xxxx_zero(zero_b), .sample_in(smp_b),
    .ch_sel(ch_b), .ch_out(chout_b), .out_valid(ov_b), .clip(clip_b), .overrun(ovr_b)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Expected published buses of the small instance from the current stimulus.
  task automatic model_a();
    longint s, cl;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int i = 0; i < A_SLOTS; i++) if (chs_a[i] == c) s += vals_a[i];
      cl = clamp(s, 8);
      exp_ch_a[c*8 +: 8] = 8'(cl);
      exp_clip_a[c]      = (cl != s);
    end
  endtask

  task automatic fill_a_random();
    for (int i = 0; i < A_SLOTS; i++) begin
      vals_a[i] = int'($urandom_range(0, 255)) - 128;
      chs_a[i]  = int'($urandom_range(0, 1));
    end
  endtask

  // One frame of the small instance, cycle by cycle from trigger to publish.
  task automatic run_a(input bit pre, input int glitch_k, input bit trig_end, input int rst_k);
    int s;
    if (!pre) begin
      @(negedge clk);
      trig_a = 1'b1;
    end
    for (int k = 1; k <= A_FR; k++) begin
      @(negedge clk);
      trig_a = 1'b0;
      if (k == A_FR) model_a();
      check_val("a_slot_valid", sv_a, (k <= A_SLOTS));
      if (k <= A_SLOTS) check_val("a_xxxx", xxxx_a, k - 1);
      check_val("a_xxxx_zero", zero_a, (k == 1));
      check_val("a_busy", busy_a, (k < A_FR));
      check_val("a_out_valid", ov_a, (k == A_FR));
      check_val("a_ch_out", chout_a, exp_ch_a);
      check_val("a_clip", clip_a, exp_clip_a);
      check_val("a_overrun", ovr_a, exp_ovr_a);
      s = k - 1 - A_LAT;
      if (s >= 0 && s < A_SLOTS) begin
        smp_a = vals_a[s][7:0];
        ch_a  = chs_a[s][0];
      end else begin
        smp_a = 8'($urandom);
        ch_a  = 1'($urandom);
      end
      if (k == glitch_k) begin
        trig_a    = 1'b1;
        exp_ovr_a = 1'b1;
      end
      if (k == A_FR && trig_end) trig_a = 1'b1;
      if (k == rst_k) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        exp_ch_a   = '0;
        exp_clip_a = '0;
        exp_ovr_a  = 1'b0;
        check_val("rst_busy", busy_a, 1'b0);
        check_val("rst_slot_valid", sv_a, 1'b0);
        check_val("rst_ch_out", chout_a, 16'h0000);
        check_val("rst_clip", clip_a, 2'b00);
        check_val("rst_out_valid", ov_a, 1'b0);
        check_val("rst_overrun", ovr_a, 1'b0);
        for (int j = 0; j < A_FR; j++) begin
          @(negedge clk);
          check_val("rst_no_publish", ov_a, 1'b0);
        end
        return;
      end
    end
  endtask

  // One frame of the default-sized instance; ch_sel 3 has no channel there.
  task automatic run_b();
    int s;
    longint sum, cl;
    logic [71:0] exp_ch;
    logic [2:0]  exp_clip;
    @(negedge clk);
    trig_b = 1'b1;
    for (int k = 1; k <= B_FR; k++) begin
      @(negedge clk);
      trig_b = 1'b0;
      if (k == 1) begin
        check_val("b_first_slot", {sv_b, zero_b, xxxx_b}, {2'b11, 9'd0});
      end
      if (k == B_SLOTS) check_val("b_last_slot", xxxx_b, 9'd511);
      if (k == B_FR - 1) check_val("b_early_valid", ov_b, 1'b0);
      if (k == B_FR) begin
        for (int c = 0; c < 3; c++) begin
          sum = 0;
          for (int i = 0; i < B_SLOTS; i++) if (chs_b[i] == c) sum += vals_b[i];
          sum = sum >>> 4;
          cl  = clamp(sum, 24);
          exp_ch[c*24 +: 24] = 24'(cl);
          exp_clip[c]        = (cl != sum);
        end
        check_val("b_out_valid", ov_b, 1'b1);
        check_val("b_ch_out", chout_b, exp_ch);
        check_val("b_clip", clip_b, exp_clip);
        check_val("b_overrun", ovr_b, 1'b0);
      end
      s = k - 1 - B_LAT;
      if (s >= 0 && s < B_SLOTS) begin
        smp_b = 17'(vals_b[s]);
        ch_b  = 2'(chs_b[s]);
      end else begin
        smp_b = 17'($urandom);
        ch_b  = 2'($urandom);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    trig_a = 1'b0; smp_a = '0; ch_a = 1'b0;
    trig_b = 1'b0; smp_b = '0; ch_b = '0;
    exp_ch_a = '0; exp_clip_a = '0; exp_ovr_a = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy_a, 1'b0);
    check_val("reset_slot_valid", sv_a, 1'b0);
    check_val("reset_ch_out", chout_a, 16'h0000);
    check_val("reset_clip", clip_a, 2'b00);
    check_val("reset_overrun", ovr_a, 1'b0);
    check_val("reset_out_valid", ov_a, 1'b0);
    check_val("reset_b_ch_out", chout_b, 72'h0);
    rst_n = 1'b1;

    for (int i = 0; i < A_SLOTS; i++) begin vals_a[i] = 10; chs_a[i] = 0; end
    run_a(1'b0, 0, 1'b0, 0);

    vals_a = '{100, 100, -100, -100};
    chs_a  = '{0, 0, 1, 1};
    run_a(1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_a_random();
      run_a(1'b0, 0, 1'b0, 0);
    end

    fill_a_random();
    run_a(1'b0, 3, 1'b1, 0);
    fill_a_random();
    run_a(1'b1, 0, 1'b0, 0);

    fill_a_random();
    run_a(1'b0, 0, 1'b0, 3);
    fill_a_random();
    run_a(1'b0, 0, 1'b0, 0);

    for (int i = 0; i < B_SLOTS; i++) begin vals_b[i] = 1000; chs_b[i] = 0; end
    run_b();
    for (int i = 0; i < B_SLOTS; i++) begin
      vals_b[i] = int'($urandom_range(0, 131071)) - 65536;
      chs_b[i]  = int'($urandom_range(0, 3));
    end
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
